modexp_ctrl: RTL

//  Computes result = base^exp mod n by right-to-left square-and-multiply.
//  - Acts as the requester side of the modmult go/done handshake.
//  - Drives one external modmult instance that it shares for every multiply and square.
//  - Sits between the RSA top level (encrypt/decrypt request) and the multiplier.

---
 rtl/rsa_pkg.sv | 16 +
 rtl/modexp_ctrl_if.sv | 25 ++
 rtl/modexp_ctrl.sv | 135 +++++++++++++
 3 files changed

// File: rtl/rsa_pkg.sv
// Shared types and constants for the RSA datapath controllers.
package rsa_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        MUL_ISSUE = 3'd1,
        MUL_WAIT  = 3'd2,
        SQR_ISSUE = 3'd3,
        SQR_WAIT  = 3'd4,
        FINISH    = 3'd5
    } modexp_state_t;

    // Multiplicative identity; sized to the operand width at the point of use.
    localparam int unsigned MODEXP_ONE = 1;

endpackage

// File: rtl/modexp_ctrl_if.sv
// Request/complete link between modexp_ctrl (master) and one shared modmult (slave).
interface modexp_ctrl_if #(
    parameter int WIDTH = 32
);
    // go/done handshake: the master pulses mm_go for one cycle with mm_a/mm_b/mm_n
    // stable until the slave pulses mm_done for one cycle alongside mm_result;
    // the master never raises mm_go in the same cycle it sees mm_done.
    logic             mm_go;
    logic [WIDTH-1:0] mm_a;
    logic [WIDTH-1:0] mm_b;
    logic [WIDTH-1:0] mm_n;
    logic [WIDTH-1:0] mm_result;
    logic             mm_done;

    modport master (
        output mm_go, mm_a, mm_b, mm_n,
        input  mm_result, mm_done
    );

    modport slave (
        input  mm_go, mm_a, mm_b, mm_n,
        output mm_result, mm_done
    );

endinterface

// File: rtl/modexp_ctrl.sv
// Right-to-left square-and-multiply controller computing base^exp mod n
// through a single shared modmult unit.
import rsa_pkg::*;

module modexp_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 go,
    input  logic [WIDTH-1:0]     base,
    input  logic [WIDTH-1:0]     exp,
    input  logic [WIDTH-1:0]     n,
    output logic [WIDTH-1:0]     result,
    output logic                 done,
    output logic                 busy,
    output modexp_state_t        state,
    modexp_ctrl_if.master        mm
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(MODEXP_ONE);

    modexp_state_t    state_q, state_d;
    logic [WIDTH-1:0] base_r, base_d;
    logic [WIDTH-1:0] exp_r, exp_d;
    logic [WIDTH-1:0] n_r, n_d;
    logic [WIDTH-1:0] acc_r, acc_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] mm_a_q, mm_a_d;
    logic [WIDTH-1:0] mm_b_q, mm_b_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic             mm_go_q, mm_go_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            base_r   <= '0;
            exp_r    <= '0;
            n_r      <= '0;
            acc_r    <= '0;
            result_q <= '0;
            mm_a_q   <= '0;
            mm_b_q   <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            mm_go_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            base_r   <= base_d;
            exp_r    <= exp_d;
            n_r      <= n_d;
            acc_r    <= acc_d;
            result_q <= result_d;
            mm_a_q   <= mm_a_d;
            mm_b_q   <= mm_b_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            mm_go_q  <= mm_go_d;
        end
    end

    always_comb begin
        state_d = state_q;
        base_d  = base_r;
        exp_d   = exp_r;
        n_d     = n_r;
        acc_d   = acc_r;

        case (state_q)
            IDLE: begin
                if (go) begin
                    base_d = base;
                    exp_d  = exp;
                    n_d    = n;
                    // n of 0 or 1 makes every residue 0; acc=1 is only valid mod n>=2
                    if (n <= ONE) begin
                        acc_d   = '0;
                        state_d = FINISH;
                    end else begin
                        acc_d = ONE;
                        if (exp == '0)  state_d = FINISH;
                        else if (exp[0]) state_d = MUL_ISSUE;
                        else            state_d = SQR_ISSUE;
                    end
                end
            end
            MUL_ISSUE: state_d = MUL_WAIT;
            MUL_WAIT: begin
                if (mm.mm_done) begin
                    acc_d   = mm.mm_result;
                    // Last set bit consumed: the trailing square would be wasted work.
                    state_d = ((exp_r >> 1) == '0) ? FINISH : SQR_ISSUE;
                end
            end
            SQR_ISSUE: state_d = SQR_WAIT;
            SQR_WAIT: begin
                if (mm.mm_done) begin
                    base_d  = mm.mm_result;
                    exp_d   = exp_r >> 1;
                    state_d = exp_r[1] ? MUL_ISSUE : SQR_ISSUE;
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next-state view so they line up with the state they describe.
    always_comb begin
        mm_go_d  = (state_d == MUL_ISSUE) || (state_d == SQR_ISSUE);
        mm_a_d   = mm_a_q;
        mm_b_d   = mm_b_q;
        if (state_d == MUL_ISSUE) begin
            mm_a_d = acc_d;
            mm_b_d = base_d;
        end else if (state_d == SQR_ISSUE) begin
            mm_a_d = base_d;
            mm_b_d = base_d;
        end
        done_d   = (state_d == FINISH);
        result_d = (state_d == FINISH) ? acc_d : result_q;
        busy_d   = (state_d != IDLE);
    end

    assign result    = result_q;
    assign done      = done_q;
    assign busy      = busy_q;
    assign state     = state_q;
    assign mm.mm_go  = mm_go_q;
    assign mm.mm_a   = mm_a_q;
    assign mm.mm_b   = mm_b_q;
    assign mm.mm_n   = n_r;

endmodule
